bcd_clock_display_scan: RTL and testbench

//   Display-side consumer of the 12-hour BCD clock (pm, hh, mm, ss). Captures a coherent

---
 rtl/bcd_clock_display_scan.sv | 119 +++++++++++
 tb/tb_bcd_clock_display_scan.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bcd_clock_display_scan.sv
// Snapshot of a 12-hour BCD time scanned onto a 6-digit multiplexed 7-segment display.
// Optional macro LZ_BLANK_EN: blank the hours-tens digit when it is zero.
module bcd_clock_display_scan #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       pm,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       pm_led
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] r_presc;
  logic [2:0]    r_dig;
  logic          r_pm;
  logic [7:0]    r_hh;
  logic [7:0]    r_mm;
  logic [7:0]    r_ss;
  logic [5:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_pm_led;

  logic [3:0]    w_nib;
  logic [5:0]    w_an;
  logic [6:0]    w_seg;
  logic          w_dp;

  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] res;
    case (nib)
      4'd0:    res = 7'h3F;
      4'd1:    res = 7'h06;
      4'd2:    res = 7'h5B;
      4'd3:    res = 7'h4F;
      4'd4:    res = 7'h66;
      4'd5:    res = 7'h6D;
      4'd6:    res = 7'h7D;
      4'd7:    res = 7'h07;
      4'd8:    res = 7'h7F;
      4'd9:    res = 7'h6F;
      default: res = 7'h40;
    endcase
    return res;
  endfunction

  // Select the nibble, digit enable and colon for the digit currently being scanned.
  always_comb begin
    w_nib = 4'h0;
    w_an  = 6'b000000;
    w_dp  = 1'b0;
    case (r_dig)
      3'd0: begin w_nib = r_ss[3:0]; w_an = 6'b000001; end
      3'd1: begin w_nib = r_ss[7:4]; w_an = 6'b000010; end
      3'd2: begin w_nib = r_mm[3:0]; w_an = 6'b000100; w_dp = 1'b1; end
      3'd3: begin w_nib = r_mm[7:4]; w_an = 6'b001000; end
      3'd4: begin w_nib = r_hh[3:0]; w_an = 6'b010000; w_dp = 1'b1; end
      3'd5: begin w_nib = r_hh[7:4]; w_an = 6'b100000; end
      default: begin w_nib = 4'h0; w_an = 6'b000000; w_dp = 1'b0; end
    endcase
`ifdef LZ_BLANK_EN
    // Blanked digit keeps its anode on so every digit gets the same duty cycle.
    if ((r_dig == 3'd5) && (r_hh[7:4] == 4'h0)) begin
      w_seg = 7'h00;
    end else begin
      w_seg = seg7_decode(w_nib);
    end
`else
    w_seg = seg7_decode(w_nib);
`endif
  end

  // Snapshot capture, scan prescaler/digit counter and registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc  <= '0;
      r_dig    <= 3'd0;
      r_pm     <= 1'b0;
      r_hh     <= 8'h12;
      r_mm     <= 8'h00;
      r_ss     <= 8'h00;
      r_an     <= 6'b000000;
      r_seg    <= 7'h00;
      r_dp     <= 1'b0;
      r_pm_led <= 1'b0;
    end else begin
      if (load) begin
        r_pm <= pm;
        r_hh <= hh;
        r_mm <= mm;
        r_ss <= ss;
      end
      if (r_presc == PW'(SCAN_DIV - 1)) begin
        r_presc <= '0;
        r_dig   <= (r_dig == 3'd5) ? 3'd0 : r_dig + 3'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      r_an     <= w_an;
      r_seg    <= w_seg;
      r_dp     <= w_dp;
      r_pm_led <= r_pm;
    end
  end

  assign an     = r_an;
  assign seg    = r_seg;
  assign dp     = r_dp;
  assign pm_led = r_pm_led;

endmodule

// File: tb/tb_bcd_clock_display_scan.sv
// Directed self-checking bench for bcd_clock_display_scan (SCAN_DIV=4 and SCAN_DIV=1 instances).
module tb_bcd_clock_display_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic       pm = 1'b0;
  logic [7:0] hh = 8'h12;
  logic [7:0] mm = 8'h00;
  logic [7:0] ss = 8'h00;
  logic [5:0] an, an_b;
  logic [6:0] seg, seg_b;
  logic       dp, dp_b;
  logic       pm_led, pm_led_b;

  int checks = 0;
  int failures = 0;

`ifdef LZ_BLANK_EN
  localparam logic [6:0] HT_ZERO = 7'h00;
`else
  localparam logic [6:0] HT_ZERO = 7'h3F;
`endif

  bcd_clock_display_scan #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .load(load), .pm(pm), .hh(hh), .mm(mm), .ss(ss),
    .an(an), .seg(seg), .dp(dp), .pm_led(pm_led)
  );

  bcd_clock_display_scan #(.SCAN_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .load(load), .pm(pm), .hh(hh), .mm(mm), .ss(ss),
    .an(an_b), .seg(seg_b), .dp(dp_b), .pm_led(pm_led_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1ns after the reset edge R with reset released.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    load  = 1'b0;
    tick();
    check_eq({tag, "_rst_an"}, {26'd0, an}, 32'd0);
    check_eq({tag, "_rst_seg"}, {25'd0, seg}, 32'd0);
    check_eq({tag, "_rst_dp"}, {31'd0, dp}, 32'd0);
    check_eq({tag, "_rst_pm"}, {31'd0, pm_led}, 32'd0);
    reset = 1'b0;
  endtask

  // Checks edges R+first_k .. R+24; edge R+k shows digit (k-1)/4. exp = {d5,d4,d3,d2,d1,d0}.
  task automatic run_scan(input string tag, input logic [41:0] exp, input int first_k);
    int d;
    for (int k = first_k; k <= 24; k++) begin
      tick();
      d = (k - 1) / 4;
      check_eq($sformatf("%s_an_e%0d", tag, k), {26'd0, an}, 32'd1 << d);
      check_eq($sformatf("%s_seg_e%0d", tag, k), {25'd0, seg}, {25'd0, exp[d*7 +: 7]});
      check_eq($sformatf("%s_dp_e%0d", tag, k), {31'd0, dp}, ((d == 2) || (d == 4)) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    // 1: reset snapshot 12:00:00 scanned at SCAN_DIV=4
    do_reset("t1");
    run_scan("t1", {7'h06, 7'h5B, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1);
    tick();
    check_eq("t1_wrap_an", {26'd0, an}, 32'h01);
    check_eq("t1_pm_led", {31'd0, pm_led}, 32'd0);

    // 2: load pm=1 09:59:30 on the first edge after reset
    do_reset("t2");
    pm = 1'b1; hh = 8'h09; mm = 8'h59; ss = 8'h30; load = 1'b1;
    tick();
    load = 1'b0;
    check_eq("t2_pm_led_e1", {31'd0, pm_led}, 32'd0);
    check_eq("t2_seg_e1", {25'd0, seg}, 32'h3F);
    tick();
    check_eq("t2_pm_led_e2", {31'd0, pm_led}, 32'd1);
    check_eq("t2_seg_e2", {25'd0, seg}, 32'h3F);
    run_scan("t2", {HT_ZERO, 7'h6F, 7'h6D, 7'h6F, 7'h4F, 7'h3F}, 3);

    // 3: seconds ones nibble out of range shows a dash
    do_reset("t3");
    pm = 1'b0; hh = 8'h12; mm = 8'h00; ss = 8'h5A; load = 1'b1;
    tick();
    load = 1'b0;
    run_scan("t3", {7'h06, 7'h5B, 7'h3F, 7'h3F, 7'h6D, 7'h40}, 2);

    // 4: hours change 11->12 mid-dig4 without disturbing the scan
    do_reset("t4");
    hh = 8'h11; mm = 8'h00; ss = 8'h00; load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 2; k <= 16; k++) tick();
    tick();
    check_eq("t4_an_e17", {26'd0, an}, 32'h10);
    check_eq("t4_seg_e17", {25'd0, seg}, 32'h06);
    hh = 8'h12; load = 1'b1;
    tick();
    load = 1'b0;
    check_eq("t4_seg_e18", {25'd0, seg}, 32'h06);
    tick();
    check_eq("t4_seg_e19", {25'd0, seg}, 32'h5B);
    check_eq("t4_an_e19", {26'd0, an}, 32'h10);
    check_eq("t4_dp_e19", {31'd0, dp}, 32'd1);
    tick();
    check_eq("t4_an_e20", {26'd0, an}, 32'h10);
    tick();
    check_eq("t4_an_e21", {26'd0, an}, 32'h20);
    check_eq("t4_seg_e21", {25'd0, seg}, 32'h06);

    // 5: reset during dig3 overrides a load captured one cycle earlier
    do_reset("t5");
    for (int k = 1; k <= 13; k++) tick();
    pm = 1'b1; hh = 8'h09; mm = 8'h59; ss = 8'h30; load = 1'b1;
    tick();
    check_eq("t5_an_e14", {26'd0, an}, 32'h08);
    load = 1'b0;
    do_reset("t5b");
    run_scan("t5", {7'h06, 7'h5B, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1);
    check_eq("t5_pm_led", {31'd0, pm_led}, 32'd0);

    // 6: SCAN_DIV=1 rotates every cycle with a clean 5->0 wrap
    pm = 1'b0; hh = 8'h12; mm = 8'h00; ss = 8'h00;
    reset = 1'b1;
    tick();
    check_eq("t6_rst_an", {26'd0, an_b}, 32'd0);
    reset = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      logic [41:0] tbl;
      int d;
      tbl = {7'h06, 7'h5B, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
      tick();
      d = (k - 1) % 6;
      check_eq($sformatf("t6_an_e%0d", k), {26'd0, an_b}, 32'd1 << d);
      check_eq($sformatf("t6_seg_e%0d", k), {25'd0, seg_b}, {25'd0, tbl[d*7 +: 7]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
